// File: rtl/vm_pkg.sv
// Shared state type, default widths/coin table and index-width helper for the
// vending-machine balance tracker.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RETURN = 2'd2
  } vm_state_t;

  localparam int kTotalBits = 31;
  localparam int kNumCh     = 3;

  // Channel 0 in the LSBs: 100, 500, 1000.
  localparam logic [kNumCh*kTotalBits-1:0] kDefaultCoinValues =
    {31'd1000, 31'd500, 31'd100};

  function automatic int vm_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Combinational greedy change selector: highest channel whose coin value fits
// in the given total, plus a flag when no coin fits at all.
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int                        TOTAL_W     = kTotalBits,
  parameter int                        NUM_CH      = kNumCh,
  parameter logic [NUM_CH*TOTAL_W-1:0] COIN_VALUES = kDefaultCoinValues,
  parameter int                        IDX_W       = vm_idx_w(NUM_CH)
) (
  input  logic [TOTAL_W-1:0] total,
  output logic [IDX_W-1:0]   idx,
  output logic               none_fits
);

  logic [NUM_CH-1:0] fits;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fit
    assign fits[gi] = (COIN_VALUES[gi*TOTAL_W +: TOTAL_W] <= total);
  end

  // Values ascend with channel index, so the last fitting channel is the largest coin.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fits[i]) idx = IDX_W'(i);
    end
  end

  assign none_fits = ~|fits;

endmodule

// File: rtl/vm_balance_tracker.sv
// Authoritative balance register: coin deposits, purchase debits, greedy change
// return with idle timeout. Optional trace output under VM_BALANCE_TRACE_EN.
module vm_balance_tracker
  import vm_pkg::*;
#(
  parameter int                        TOTAL_W     = kTotalBits,
  parameter int                        NUM_CH      = kNumCh,
  parameter logic [NUM_CH*TOTAL_W-1:0] COIN_VALUES = kDefaultCoinValues,
  parameter int                        TIMEOUT_CYC = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           coin_in,
  input  logic                        item_req,
  input  logic [TOTAL_W-1:0]          item_price,
  input  logic                        return_req,
  input  logic                        coin_out_ready,
  output logic [TOTAL_W-1:0]          current_total,
  output logic                        dispense,
  output logic                        item_reject,
  output logic                        coin_reject,
  output logic                        coin_out_valid,
  output logic [vm_idx_w(NUM_CH)-1:0] coin_out_idx,
  output logic                        return_done,
  output logic                        change_lost
);

  localparam int IDX_W = vm_idx_w(NUM_CH);
  localparam int DEP_W = TOTAL_W + $clog2(NUM_CH);
  localparam int SUM_W = DEP_W + 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  vm_state_t          state_reg, state_next;
  logic [TOTAL_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic               valid_reg, valid_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               dispense_reg, dispense_next;
  logic               item_reject_reg, item_reject_next;
  logic               coin_reject_reg, coin_reject_next;
  logic               return_done_reg, return_done_next;
  logic               change_lost_reg, change_lost_next;

  logic [DEP_W-1:0]   ch_val [NUM_CH];
  logic [TOTAL_W-1:0] coin_val [NUM_CH];
  logic [DEP_W-1:0]   dep;
  logic [TOTAL_W-1:0] debit;
  logic [SUM_W-1:0]   sum;
  logic               buy_ok, dep_fits, dep_acc;
  logic               handshake;
  logic [TOTAL_W-1:0] ret_total;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_none;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign coin_val[gi] = COIN_VALUES[gi*TOTAL_W +: TOTAL_W];
    assign ch_val[gi]   = coin_in[gi] ? DEP_W'(coin_val[gi]) : '0;
  end

  always_comb begin
    dep = '0;
    for (int i = 0; i < NUM_CH; i++) dep = dep + ch_val[i];
  end

  // Purchase is judged on the pre-update total; debit never exceeds it, so sum cannot go negative.
  assign buy_ok   = item_req && (item_price <= total_reg) && !return_req && (state_reg != RETURN);
  assign debit    = buy_ok ? item_price : '0;
  assign sum      = SUM_W'(total_reg) - SUM_W'(debit) + SUM_W'(dep);
  assign dep_fits = ~|sum[SUM_W-1:TOTAL_W];
  assign dep_acc  = (|coin_in) && dep_fits;

  assign handshake = valid_reg && coin_out_ready;
  assign ret_total = handshake ? total_reg - coin_val[idx_reg] : total_reg;

  vm_change_picker #(
    .TOTAL_W    (TOTAL_W),
    .NUM_CH     (NUM_CH),
    .COIN_VALUES(COIN_VALUES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .total    (ret_total),
    .idx      (pick_idx),
    .none_fits(pick_none)
  );

  always_comb begin
    state_next       = state_reg;
    total_next       = total_reg;
    idle_cnt_next    = '0;
    valid_next       = 1'b0;
    idx_next         = '0;
    dispense_next    = 1'b0;
    item_reject_next = 1'b0;
    coin_reject_next = 1'b0;
    return_done_next = 1'b0;
    change_lost_next = 1'b0;
    if (state_reg == RETURN) begin
      coin_reject_next = |coin_in;
      item_reject_next = item_req;
      if (valid_reg && !coin_out_ready) begin
        valid_next = 1'b1;
        idx_next   = idx_reg;
      end else if (ret_total == '0) begin
        total_next       = '0;
        return_done_next = 1'b1;
        state_next       = IDLE;
      end else if (pick_none) begin
        total_next       = '0;
        change_lost_next = 1'b1;
        return_done_next = 1'b1;
        state_next       = IDLE;
      end else begin
        total_next = ret_total;
        valid_next = 1'b1;
        idx_next   = pick_idx;
      end
    end else if (return_req) begin
      coin_reject_next = |coin_in;
      item_reject_next = item_req;
      if (total_reg != '0) state_next = RETURN;
      else                 return_done_next = 1'b1;
    end else begin
      dispense_next    = buy_ok;
      item_reject_next = item_req && !buy_ok;
      coin_reject_next = (|coin_in) && !dep_fits;
      total_next       = dep_acc ? sum[TOTAL_W-1:0] : total_reg - debit;
      if (total_next == '0) begin
        state_next = IDLE;
      end else if (buy_ok || dep_acc) begin
        state_next = ACTIVE;
      end else if (state_reg == ACTIVE && idle_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_next = RETURN;
      end else begin
        state_next    = ACTIVE;
        idle_cnt_next = idle_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      total_reg       <= '0;
      idle_cnt_reg    <= '0;
      valid_reg       <= 1'b0;
      idx_reg         <= '0;
      dispense_reg    <= 1'b0;
      item_reject_reg <= 1'b0;
      coin_reject_reg <= 1'b0;
      return_done_reg <= 1'b0;
      change_lost_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      total_reg       <= total_next;
      idle_cnt_reg    <= idle_cnt_next;
      valid_reg       <= valid_next;
      idx_reg         <= idx_next;
      dispense_reg    <= dispense_next;
      item_reject_reg <= item_reject_next;
      coin_reject_reg <= coin_reject_next;
      return_done_reg <= return_done_next;
      change_lost_reg <= change_lost_next;
    end
  end

  assign current_total  = total_reg;
  assign dispense       = dispense_reg;
  assign item_reject    = item_reject_reg;
  assign coin_reject    = coin_reject_reg;
  assign coin_out_valid = valid_reg;
  assign coin_out_idx   = idx_reg;
  assign return_done    = return_done_reg;
  assign change_lost    = change_lost_reg;

`ifdef VM_BALANCE_TRACE_EN
  always @(posedge clk) begin
    if (!reset && (total_reg != '0 || total_next != total_reg))
      $display("vm_balance_tracker: state=%s total=%0d total_nxt=%0d",
               state_reg.name(), total_reg, total_next);
  end
`endif

endmodule

// File: tb/tb_vm_balance_tracker.sv
// Directed bench: default instance (100/500/1000, 31 bits) and a narrow
// instance (50/100/500, 11 bits) for overflow, timeout and residual loss.
module tb_vm_balance_tracker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Default instance signals
  logic [2:0]  a_coin;
  logic        a_req, a_ret, a_rdy;
  logic [30:0] a_price, a_total;
  logic        a_disp, a_irej, a_crej, a_valid, a_done, a_lost;
  logic [1:0]  a_idx;

  // Narrow instance signals
  logic [2:0]  b_coin;
  logic        b_req, b_ret, b_rdy;
  logic [10:0] b_price, b_total;
  logic        b_disp, b_irej, b_crej, b_valid, b_done, b_lost;
  logic [1:0]  b_idx;

  vm_balance_tracker dut_a (
    .clk(clk), .reset(reset), .coin_in(a_coin), .item_req(a_req),
    .item_price(a_price), .return_req(a_ret), .coin_out_ready(a_rdy),
    .current_total(a_total), .dispense(a_disp), .item_reject(a_irej),
    .coin_reject(a_crej), .coin_out_valid(a_valid), .coin_out_idx(a_idx),
    .return_done(a_done), .change_lost(a_lost)
  );

  vm_balance_tracker #(
    .TOTAL_W(11), .NUM_CH(3),
    .COIN_VALUES({11'd500, 11'd100, 11'd50}),
    .TIMEOUT_CYC(100)
  ) dut_b (
    .clk(clk), .reset(reset), .coin_in(b_coin), .item_req(b_req),
    .item_price(b_price), .return_req(b_ret), .coin_out_ready(b_rdy),
    .current_total(b_total), .dispense(b_disp), .item_reject(b_irej),
    .coin_reject(b_crej), .coin_out_valid(b_valid), .coin_out_idx(b_idx),
    .return_done(b_done), .change_lost(b_lost)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_coin = '0; a_req = 0; a_ret = 0; a_rdy = 0; a_price = '0;
    b_coin = '0; b_req = 0; b_ret = 0; b_rdy = 0; b_price = '0;
    tick; tick;
    check("rst_total", a_total, 0);
    check("rst_valid", a_valid, 0);
    check("rst_disp",  a_disp, 0);
    check("rst_done",  a_done, 0);
    reset = 1'b0;

    // Deposits
    a_coin = 3'b011; tick;
    check("dep600_total", a_total, 600);
    check("dep600_crej", a_crej, 0);
    a_coin = 3'b100; tick;
    check("dep1600_total", a_total, 1600);
    check("dep1600_crej", a_crej, 0);

    // Purchases
    a_coin = '0; a_req = 1; a_price = 1000; tick;
    check("buy1000_disp", a_disp, 1);
    check("buy1000_total", a_total, 600);
    a_price = 500; tick;
    check("buy500_disp", a_disp, 1);
    check("buy500_total", a_total, 100);
    tick;
    check("buy500b_irej", a_irej, 1);
    check("buy500b_disp", a_disp, 0);
    check("buy500b_total", a_total, 100);

    // Return of a single 100 coin with ready held high
    a_req = 0; a_ret = 1; a_rdy = 1; tick;
    check("ret100_enter_valid", a_valid, 0);
    check("ret100_enter_total", a_total, 100);
    a_ret = 0; tick;
    check("ret100_valid", a_valid, 1);
    check("ret100_idx", a_idx, 0);
    tick;
    check("ret100_total", a_total, 0);
    check("ret100_done", a_done, 1);
    check("ret100_valid_off", a_valid, 0);

    // Same-cycle deposit does not fund the purchase
    a_rdy = 0; a_coin = 3'b100; a_req = 1; a_price = 1000; tick;
    check("samecyc_irej", a_irej, 1);
    check("samecyc_disp", a_disp, 0);
    check("samecyc_total", a_total, 1000);

    // Zero price always accepted
    a_coin = '0; a_price = 0; tick;
    check("zero_price_disp", a_disp, 1);
    check("zero_price_total", a_total, 1000);

    a_req = 0; a_coin = 3'b011; tick;
    a_coin = 3'b001; tick;
    check("dep1700_total", a_total, 1700);

    // Greedy return of 1700 with ready low three cycles
    a_coin = '0; a_ret = 1; tick;
    check("ret1700_enter_valid", a_valid, 0);
    a_ret = 0; tick;
    check("ret1700_valid1", a_valid, 1);
    check("ret1700_idx1", a_idx, 2);
    a_coin = 3'b001; a_req = 1; a_ret = 1; tick;
    check("ret1700_idx2", a_idx, 2);
    check("ret1700_crej", a_crej, 1);
    check("ret1700_irej", a_irej, 1);
    check("ret1700_hold_total", a_total, 1700);
    a_coin = '0; a_req = 0; a_ret = 0; tick;
    check("ret1700_valid3", a_valid, 1);
    check("ret1700_idx3", a_idx, 2);
    a_rdy = 1; tick;
    check("ret_t700", a_total, 700);
    check("ret_i1", a_idx, 1);
    tick;
    check("ret_t200", a_total, 200);
    check("ret_i0a", a_idx, 0);
    tick;
    check("ret_t100", a_total, 100);
    check("ret_i0b", a_idx, 0);
    check("ret_v100", a_valid, 1);
    tick;
    check("ret_t0", a_total, 0);
    check("ret_done", a_done, 1);
    check("ret_v0", a_valid, 0);
    a_rdy = 0; tick;
    check("ret_done_pulse", a_done, 0);

    // Return request with empty balance
    a_ret = 1; tick;
    check("ret_empty_done", a_done, 1);
    check("ret_empty_valid", a_valid, 0);
    a_ret = 0; tick;
    check("ret_empty_valid_after", a_valid, 0);

    // Narrow instance: overflow rejection
    for (int k = 1; k <= 4; k++) begin
      b_coin = 3'b100; tick;
      check("b_dep_total", b_total, 500 * k);
    end
    b_coin = 3'b010; tick;
    check("b_ovf_crej", b_crej, 1);
    check("b_ovf_total", b_total, 2000);
    b_coin = '0;

    // Idle timeout: RETURN entered 100 cycles after the last accepted deposit
    repeat (99) tick;
    check("b_tmo_early_valid", b_valid, 0);
    tick;
    check("b_tmo_valid", b_valid, 1);
    check("b_tmo_idx", b_idx, 2);
    b_rdy = 1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check("b_drain_total", b_total, 2000 - 500 * k);
    end
    check("b_drain_done", b_done, 1);
    b_rdy = 0;

    // Residual below the smallest coin is discarded
    b_coin = 3'b001; tick;
    check("b_dep50_total", b_total, 50);
    b_coin = '0; b_req = 1; b_price = 20; tick;
    check("b_buy20_disp", b_disp, 1);
    check("b_buy20_total", b_total, 30);
    b_req = 0; b_ret = 1; tick;
    check("b_lost_enter_total", b_total, 30);
    b_ret = 0; tick;
    check("b_lost_valid", b_valid, 0);
    check("b_lost_pulse", b_lost, 1);
    check("b_lost_done", b_done, 1);
    check("b_lost_total", b_total, 0);
    tick;
    check("b_lost_pulse_off", b_lost, 0);

    // Reset in the middle of a return
    b_coin = 3'b100; tick;
    b_coin = '0; b_ret = 1; tick;
    b_ret = 0; tick;
    check("b_mid_valid", b_valid, 1);
    reset = 1'b1; tick;
    check("b_rst_valid", b_valid, 0);
    check("b_rst_total", b_total, 0);
    check("b_rst_idx", b_idx, 0);
    check("b_rst_done", b_done, 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
